// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard.
// x0 reads as zero and is never busy; optional same-cycle write-to-read forwarding.
module regfile_mp #(
  parameter int XLEN      = 64,
  parameter int ADDR_SIZE = 5,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2,
  parameter int BYPASS    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_RD-1:0]           read_enable,
  input  logic [NUM_RD*ADDR_SIZE-1:0] read_addr,
  output logic [NUM_RD*XLEN-1:0]      read_data,
  output logic [NUM_RD-1:0]           read_busy,
  input  logic [NUM_WR-1:0]           write_enable,
  input  logic [NUM_WR*ADDR_SIZE-1:0] write_addr,
  input  logic [NUM_WR*XLEN-1:0]      write_data,
  input  logic                        reserve_enable,
  input  logic [ADDR_SIZE-1:0]        reserve_addr,
  output logic                        reserve_ok
);
  localparam int NUM_REGS = 2 ** ADDR_SIZE;

  logic signed [XLEN-1:0]  regs [1:NUM_REGS-1];
  logic [NUM_REGS-1:1]     busy;

  logic [ADDR_SIZE-1:0]    wr_addr [NUM_WR];
  logic signed [XLEN-1:0]  wr_data [NUM_WR];
  logic [NUM_WR-1:0]       wr_vld;
  logic                    res_vld;

  // Unpack write ports; a write to x0 is not a valid write at all.
  always_comb begin
    for (int w = 0; w < NUM_WR; w++) begin
      wr_addr[w] = write_addr[w*ADDR_SIZE +: ADDR_SIZE];
      wr_data[w] = write_data[w*XLEN +: XLEN];
      wr_vld[w]  = write_enable[w] && (wr_addr[w] != '0);
    end
  end

  assign res_vld = reserve_enable && (reserve_addr != '0);

  // Ascending port order lets the highest-indexed writer win; the reserve
  // is applied last so a new producer keeps the register busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
      busy <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_vld[w]) begin
          regs[wr_addr[w]] <= wr_data[w];
          busy[wr_addr[w]] <= 1'b0;
        end
      end
      if (res_vld) begin
        busy[reserve_addr] <= 1'b1;
      end
    end
  end

  assign reserve_ok = reserve_enable && (!res_vld || !busy[reserve_addr]);

  always_comb begin
    logic [ADDR_SIZE-1:0]   ra;
    logic signed [XLEN-1:0] lane;
    logic                   lane_busy;
    read_data = '0;
    read_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra        = read_addr[i*ADDR_SIZE +: ADDR_SIZE];
      lane      = '0;
      lane_busy = 1'b0;
      if (read_enable[i] && (ra != '0)) begin
        lane      = regs[ra];
        lane_busy = busy[ra];
        if (BYPASS != 0) begin
          for (int w = 0; w < NUM_WR; w++) begin
            if (wr_vld[w] && (wr_addr[w] == ra)) begin
              lane      = wr_data[w];
              lane_busy = res_vld && (reserve_addr == ra);
            end
          end
        end
      end
      read_data[i*XLEN +: XLEN] = lane;
      read_busy[i]              = lane_busy;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a forwarding and a non-forwarding instance share stimulus
// and are checked every cycle against an array model, plus directed literal checks.
module tb_regfile_mp;
  localparam int XLEN = 64;
  localparam int AS   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD-1:0]    rd_en;
  logic [NRD*AS-1:0] rd_addr;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AS-1:0] wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic              res_en;
  logic [AS-1:0]     res_addr;

  logic [NRD*XLEN-1:0] bp_data, nb_data;
  logic [NRD-1:0]      bp_busy, nb_busy;
  logic                bp_ok, nb_ok;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [XLEN-1:0] m_regs [32];
  bit              m_busy [32];

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .ADDR_SIZE(AS), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .read_enable(rd_en), .read_addr(rd_addr),
    .read_data(bp_data), .read_busy(bp_busy), .write_enable(wr_en),
    .write_addr(wr_addr), .write_data(wr_data), .reserve_enable(res_en),
    .reserve_addr(res_addr), .reserve_ok(bp_ok));

  regfile_mp #(.XLEN(XLEN), .ADDR_SIZE(AS), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .read_enable(rd_en), .read_addr(rd_addr),
    .read_data(nb_data), .read_busy(nb_busy), .write_enable(wr_en),
    .write_addr(wr_addr), .write_data(wr_data), .reserve_enable(res_en),
    .reserve_addr(res_addr), .reserve_ok(nb_ok));

  // Model: architectural state changes at each edge following the rules directly.
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && wr_addr[w*AS +: AS] != 0) begin
          m_regs[wr_addr[w*AS +: AS]] = wr_data[w*XLEN +: XLEN];
          m_busy[wr_addr[w*AS +: AS]] = 1'b0;
        end
      end
      if (res_en && res_addr != 0) m_busy[res_addr] = 1'b1;
    end
  end

  function automatic logic [XLEN-1:0] exp_data(int i, bit byp);
    logic [AS-1:0] a;
    logic [XLEN-1:0] d;
    a = rd_addr[i*AS +: AS];
    if (!rd_en[i] || a == 0) return '0;
    d = m_regs[a];
    if (byp)
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && wr_addr[w*AS +: AS] == a) d = wr_data[w*XLEN +: XLEN];
    return d;
  endfunction

  function automatic bit exp_busy(int i, bit byp);
    logic [AS-1:0] a;
    bit b;
    a = rd_addr[i*AS +: AS];
    if (!rd_en[i] || a == 0) return 1'b0;
    b = m_busy[a];
    if (byp)
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && wr_addr[w*AS +: AS] == a) b = res_en && (res_addr == a);
    return b;
  endfunction

  function automatic bit exp_ok();
    return res_en && (res_addr == 0 || !m_busy[res_addr]);
  endfunction

  task automatic cmp(string name, logic [XLEN-1:0] got, logic [XLEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NRD; i++) begin
        cmp($sformatf("bp_data%0d", i), bp_data[i*XLEN +: XLEN], exp_data(i, 1'b1));
        cmp($sformatf("bp_busy%0d", i), 64'(bp_busy[i]), 64'(exp_busy(i, 1'b1)));
        cmp($sformatf("nb_data%0d", i), nb_data[i*XLEN +: XLEN], exp_data(i, 1'b0));
        cmp($sformatf("nb_busy%0d", i), 64'(nb_busy[i]), 64'(exp_busy(i, 1'b0)));
      end
      cmp("bp_ok", 64'(bp_ok), 64'(exp_ok()));
      cmp("nb_ok", 64'(nb_ok), 64'(exp_ok()));
    end
  end

  task automatic idle();
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    res_en = 1'b0; res_addr = '0;
  endtask

  task automatic set_rd(int i, bit en, int a);
    rd_en[i] = en;
    rd_addr[i*AS +: AS] = AS'(a);
  endtask

  task automatic set_wr(int w, bit en, int a, logic [XLEN-1:0] d);
    wr_en[w] = en;
    wr_addr[w*AS +: AS] = AS'(a);
    wr_data[w*XLEN +: XLEN] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // Cleared state, x0 writes dropped (also under same-cycle forwarding)
    set_rd(0, 1, 5); set_rd(1, 1, 31);
    #1;
    cmp("lit_x5", bp_data[0 +: XLEN], 64'h0);
    cmp("lit_x31_busy", 64'(bp_busy[1]), 64'h0);
    tick();
    set_wr(0, 1, 0, 64'hDEAD); set_rd(0, 1, 0);
    #1;
    cmp("lit_x0_fwd", bp_data[0 +: XLEN], 64'h0);
    tick();
    set_wr(0, 0, 0, '0);
    #1;
    cmp("lit_x0", bp_data[0 +: XLEN], 64'h0);
    tick();

    // Two ports hit x3: port 1 wins
    set_wr(0, 1, 3, 64'h11); set_wr(1, 1, 3, 64'h22);
    tick();
    idle(); set_rd(0, 1, 3);
    #1;
    cmp("lit_x3_prio", bp_data[0 +: XLEN], 64'h22);
    tick();

    // Forwarding vs stored value
    set_wr(0, 1, 7, 64'hABCD); set_rd(0, 1, 7);
    #1;
    cmp("lit_x7_bp", bp_data[0 +: XLEN], 64'hABCD);
    cmp("lit_x7_nb", nb_data[0 +: XLEN], 64'h0);
    tick();
    idle(); set_rd(0, 1, 7);
    #1;
    cmp("lit_x7_nb_next", nb_data[0 +: XLEN], 64'hABCD);
    tick();

    // Scoreboard on x9
    idle(); res_en = 1; res_addr = 9;
    #1;
    cmp("lit_res9_ok", 64'(bp_ok), 64'h1);
    tick();
    set_rd(0, 1, 9);
    #1;
    cmp("lit_x9_busy", 64'(bp_busy[0]), 64'h1);
    cmp("lit_res9_waw", 64'(bp_ok), 64'h0);
    tick();
    idle(); set_wr(0, 1, 9, 64'h5); set_rd(1, 1, 9);
    #1;
    cmp("lit_x9_fwd_busy", 64'(bp_busy[1]), 64'h0);
    cmp("lit_x9_nb_busy", 64'(nb_busy[1]), 64'h1);
    tick();
    idle(); set_rd(0, 1, 9);
    #1;
    cmp("lit_x9_data", bp_data[0 +: XLEN], 64'h5);
    cmp("lit_x9_clear", 64'(bp_busy[0]), 64'h0);
    tick();

    // Reserve and write the same register: stays busy, data stored
    idle(); res_en = 1; res_addr = 4; set_wr(1, 1, 4, 64'h77); set_rd(0, 1, 4);
    #1;
    cmp("lit_x4_fwd_busy", 64'(bp_busy[0]), 64'h1);
    tick();
    idle(); set_rd(0, 1, 4); set_rd(1, 0, 4);
    #1;
    cmp("lit_x4_busy", 64'(nb_busy[0]), 64'h1);
    cmp("lit_x4_data", nb_data[0 +: XLEN], 64'h77);
    cmp("lit_rd_dis_data", bp_data[XLEN +: XLEN], 64'h0);
    cmp("lit_rd_dis_busy", 64'(bp_busy[1]), 64'h0);
    res_en = 1; res_addr = 0;
    #1;
    cmp("lit_res_x0_ok", 64'(bp_ok), 64'h1);
    tick();

    // Reset right after a reserve+write
    idle(); res_en = 1; res_addr = 12; set_wr(0, 1, 12, 64'h1);
    tick();
    idle(); rst = 1'b1;
    tick();
    rst = 1'b0; res_en = 1; res_addr = 12; set_rd(0, 1, 12);
    #1;
    cmp("lit_x12_data", bp_data[0 +: XLEN], 64'h0);
    cmp("lit_x12_busy", 64'(bp_busy[0]), 64'h0);
    cmp("lit_x12_ok", 64'(bp_ok), 64'h1);
    tick();

    // Dense traffic over a few registers to provoke collisions
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NRD; i++) set_rd(i, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 7));
      for (int w = 0; w < NWR; w++)
        set_wr(w, 1'($urandom_range(0, 1)), $urandom_range(0, 7), {$urandom, $urandom});
      res_en = 1'($urandom_range(0, 1));
      res_addr = AS'($urandom_range(0, 7));
      tick();
    end

    idle();
    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
